wait_sram: RTL and testbench

Writable word-wide memory responder for the device side of the external memory interface. It holds a `DEPTH`-word synchronous RAM and answers `re_i`/`we_i` requests through the shared tri-state `data_io` bus, stretching each access with a programmable number of wait states via `needWait_o`. It occupies the SRAM slot next to the test ROM and exercises the CPU's wait-handling path with a read/write target.

---
 rtl/wait_sram_pkg.sv | 13 +
 rtl/wait_sram_array.sv | 30 +++
 rtl/wait_sram.sv | 122 ++++++++++++
 tb/tb_wait_sram.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wait_sram_pkg.sv
// Shared bus types for memory-slot responders.
// Response FSM encoding and bus data width.
package wait_sram_pkg;

  localparam int BUS_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } mem_resp_state_t;

endpackage

// File: rtl/wait_sram_array.sv
// 1R1W synchronous RAM with registered read.
// Shaped to map onto a block RAM.
module sram_array #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [2**AW];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wait_sram.sv
// Wait-state SRAM responder on the shared tri-state bus.
// Each access is stretched by WAIT_CYCLES via need_wait.
module wait_sram
  import wait_sram_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  re_i,
  input  logic                  we_i,
  inout  wire  [BUS_DATA_W-1:0] data_io,
  output logic                  needWait_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  mem_resp_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  err_q;
  logic                  req;
  logic                  ram_re, ram_we;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [BUS_DATA_W-1:0] rdata;
  logic                  unused_addr;

  assign req         = re_i | we_i;
  assign unused_addr = ^addr_i[ADDR_W-1:DEPTH_LOG2];

  // state, counter and latched request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
    end
  end

  // next state, RAM read issue and write commit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_raddr = addr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = addr_i[DEPTH_LOG2-1:0];
          rd_d   = re_i;
          cnt_d  = CNT_INIT;
          if (WAIT_CYCLES == 1) begin
            state_d   = READY;
            ram_re    = 1'b1;
            ram_raddr = addr_i[DEPTH_LOG2-1:0];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = READY;
          cnt_d   = '0;
          ram_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        state_d = IDLE;
        ram_we  = req && !rd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // sticky conflict flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)             err_q <= 1'b0;
    else if (re_i && we_i)  err_q <= 1'b1;
  end

  sram_array #(
    .AW (DEPTH_LOG2),
    .DW (BUS_DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rdata),
    .we    (ram_we),
    .waddr (addr_q),
    .wdata (data_io)
  );

  assign data_io = (state_q == READY && rd_q && re_i) ? rdata : 'z;

  assign needWait_o = req && (state_q != READY);
  assign err_o      = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_wait_sram.sv
// Directed bench for wait_sram.
// Two instances: WAIT_CYCLES=2 and WAIT_CYCLES=1.
module tb_wait_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  re, we, drv_en;
  logic [20:0] addr [2];
  logic [15:0] drv  [2];
  wire  [1:0]  nw, err;
  wire  [1:0]  st0, st1;
  tri1  [15:0] bus0, bus1;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] rdv;
  int          waits;

  always #5 clk = ~clk;

  assign bus0 = drv_en[0] ? drv[0] : 'z;
  assign bus1 = drv_en[1] ? drv[1] : 'z;

  wait_sram #(.ADDR_W(21), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr[0]),
    .re_i       (re[0]),
    .we_i       (we[0]),
    .data_io    (bus0),
    .needWait_o (nw[0]),
    .err_o      (err[0]),
    .dbg_state  (st0)
  );

  wait_sram #(.ADDR_W(21), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr[1]),
    .re_i       (re[1]),
    .we_i       (we[1]),
    .data_io    (bus1),
    .needWait_o (nw[1]),
    .err_o      (err[1]),
    .dbg_state  (st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one full access; starts just after a rising edge, ends likewise
  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [20:0] a, input logic [15:0] wd,
                        output logic [15:0] rv, output int nwait);
    re[s]     = rd;
    we[s]     = wr;
    addr[s]   = a;
    drv[s]    = wd;
    drv_en[s] = wr && !rd;
    nwait     = 0;
    #1;
    while (nw[s] && nwait < 20) begin
      nwait++;
      @(posedge clk);
      #1;
    end
    rv = (s == 1) ? bus1 : bus0;
    @(posedge clk);
    #1;
    re[s]     = 1'b0;
    we[s]     = 1'b0;
    drv_en[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    re     = '0;
    we     = '0;
    drv_en = '0;
    addr[0] = '0; addr[1] = '0;
    drv[0]  = '0; drv[1]  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", st0, 0);
    chk("rst_err", err[0], 0);
    chk("rst_nw", nw[0], 0);
    chk("rst_bus", bus0, 16'hffff);
    rst_n = 1'b1;

    // write then read, 2 wait states
    access(0, 0, 1, 21'h005, 16'hbeef, rdv, waits);
    chk("wr_waits", waits, 2);
    access(0, 1, 0, 21'h005, 16'h0000, rdv, waits);
    chk("rd_waits", waits, 2);
    chk("rd_beef", rdv, 16'hbeef);
    chk("rd_release", bus0, 16'hffff);
    chk("rd_idle", st0, 0);

    // upper address bits alias
    access(0, 0, 1, 21'h405, 16'h1234, rdv, waits);
    access(0, 1, 0, 21'h005, 16'h0000, rdv, waits);
    chk("alias", rdv, 16'h1234);

    // single wait state, read right after write
    access(1, 0, 1, 21'h007, 16'haaaa, rdv, waits);
    chk("w1_wr_waits", waits, 1);
    access(1, 1, 0, 21'h007, 16'h0000, rdv, waits);
    chk("w1_rd_waits", waits, 1);
    chk("w1_rd", rdv, 16'haaaa);

    // abort a write in WAIT
    access(0, 0, 1, 21'h010, 16'h0000, rdv, waits);
    we[0]     = 1'b1;
    addr[0]   = 21'h010;
    drv[0]    = 16'h5555;
    drv_en[0] = 1'b1;
    #1;
    chk("ab_nw0", nw[0], 1);
    @(posedge clk);
    #1;
    chk("ab_wait", st0, 1);
    we[0]     = 1'b0;
    drv_en[0] = 1'b0;
    #1;
    chk("ab_nw", nw[0], 0);
    chk("ab_bus", bus0, 16'hffff);
    @(posedge clk);
    #1;
    chk("ab_idle", st0, 0);
    chk("ab_bus2", bus0, 16'hffff);
    access(0, 1, 0, 21'h010, 16'h0000, rdv, waits);
    chk("ab_rd", rdv, 16'h0000);

    // read and write together
    access(0, 0, 1, 21'h020, 16'h00c3, rdv, waits);
    chk("err_pre", err[0], 0);
    access(0, 1, 1, 21'h020, 16'h0000, rdv, waits);
    chk("both_rd", rdv, 16'h00c3);
    chk("err_set", err[0], 1);
    access(0, 1, 0, 21'h020, 16'h0000, rdv, waits);
    chk("both_ram", rdv, 16'h00c3);
    chk("err_hold", err[0], 1);

    // reset during WAIT of a write
    access(0, 0, 1, 21'h030, 16'h1111, rdv, waits);
    we[0]     = 1'b1;
    addr[0]   = 21'h030;
    drv[0]    = 16'h7777;
    drv_en[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_wait", st0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    we[0]     = 1'b0;
    drv_en[0] = 1'b0;
    #1;
    chk("rw_idle", st0, 0);
    chk("rw_err", err[0], 0);
    chk("rw_bus", bus0, 16'hffff);
    chk("rw_nw", nw[0], 0);
    access(0, 1, 0, 21'h030, 16'h0000, rdv, waits);
    chk("rw_nowrite", rdv, 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
